npc_bp: RTL

- Parametrised next-PC generator with a fetch-side PC register, a direct-mapped branch predictor (BHT/BTB), and EX-side resolution/redirect.
- Generalises the combinational branch/jal/jalr next-PC selection: adds a prediction at fetch, detects mispredicts in EX, trains the table, and drives flush/redirect.
- Sits between IF (drives pc_if) and the EX-stage branch outcome.

---
 rtl/npc_bp_pkg.sv | 13 +
 rtl/npc_bp_btb.sv | 44 ++++
 rtl/npc_bp.sv | 74 +++++++
 3 files changed

// File: rtl/npc_bp_pkg.sv
// npc_pkg: PC-select encodings, 2-bit counter states and predictor entry type
package npc_pkg;
   localparam logic [1:0] PC_SEL_SEQ = 2'b00, PC_SEL_BR = 2'b01, PC_SEL_JAL = 2'b10, PC_SEL_JALR = 2'b11;
   localparam logic [1:0] CTR_SNT = 2'b00, CTR_WNT = 2'b01, CTR_WT = 2'b10, CTR_ST = 2'b11;
   // tag and target widths depend on XLEN/IDX_W, so they live in parallel arrays in npc_btb
   typedef struct packed {
      logic       valid;
      logic [1:0] ctr;
   } btb_entry_t;
   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
      return t ? (c == CTR_ST ? c : c + 2'd1) : (c == CTR_SNT ? c : c - 2'd1);
   endfunction
endpackage

// File: rtl/npc_bp_btb.sv
// npc_btb: direct-mapped BHT/BTB, one comb read port, one sync read-modify-write port
module npc_btb import npc_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IDX_W-1:0]        rd_idx,
   input  logic [XLEN-IDX_W-3:0]   rd_tag,
   output logic                    rd_hit,
   output logic                    rd_taken,
   output logic [XLEN-1:0]         rd_target,
   input  logic                    we,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [1:0]              wr_sel,
   input  logic                    wr_taken,
   input  logic [XLEN-IDX_W-3:0]   wr_tag,
   input  logic [XLEN-1:0]         wr_target
);
   localparam int N = 2**IDX_W;
   btb_entry_t                ent  [N];
   logic [XLEN-IDX_W-3:0]     tags [N];
   logic [XLEN-1:0]           tgts [N];
   logic                      wr_hit;
   btb_entry_t                wr_ent;
   always_comb begin
      rd_hit       = ent[rd_idx].valid && tags[rd_idx] == rd_tag;
      rd_taken     = ent[rd_idx].ctr[1];
      rd_target    = tgts[rd_idx];
      wr_hit       = ent[wr_idx].valid && tags[wr_idx] == wr_tag;
      wr_ent.valid = wr_sel != PC_SEL_SEQ;
      wr_ent.ctr   = wr_sel != PC_SEL_BR ? CTR_ST :
                     wr_hit ? ctr_next(ent[wr_idx].ctr, wr_taken) : (wr_taken ? CTR_WT : CTR_WNT);
   end
   // a SEQ write is an invalidate of a stale alias; target kept on not-taken hits
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < N; i++) ent[i].valid <= 1'b0;
      else if (we) begin
         ent[wr_idx]  <= wr_ent;
         tags[wr_idx] <= wr_tag;
         if (wr_sel != PC_SEL_SEQ && (wr_taken || !wr_hit)) tgts[wr_idx] <= wr_target;
      end
endmodule

// File: rtl/npc_bp.sv
// npc_bp: fetch PC register with BHT/BTB prediction and EX-side mispredict redirect
// Define NPC_BP_PERF_CNT_EN to add perf_br_cnt/perf_mis_cnt outputs.
module npc_bp import npc_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter int              IDX_W    = 6,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   output logic [XLEN-1:0] pc_if,
   output logic            pred_taken_if,
   output logic [XLEN-1:0] pred_target_if,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [1:0]      ex_pc_sel,
   input  logic            ex_alu_branch,
   input  logic [XLEN-1:0] ex_sext,
   input  logic [XLEN-1:0] ex_rD1,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
`ifdef NPC_BP_PERF_CNT_EN
   ,
   output logic [31:0]     perf_br_cnt,
   output logic [31:0]     perf_mis_cnt
`endif
);
   logic            rd_hit, rd_taken, act_taken, ex_ctl;
   logic [XLEN-1:0] rd_target, pc4_if, actual;
   always_comb begin
      pc4_if         = pc_if + XLEN'(4);
      pred_taken_if  = !rst && rd_hit && rd_taken;
      pred_target_if = rd_hit ? rd_target : pc4_if;
      ex_ctl         = ex_pc_sel != PC_SEL_SEQ;
      act_taken      = ex_pc_sel == PC_SEL_BR ? ex_alu_branch : ex_ctl;
      actual         = ex_pc_sel == PC_SEL_JALR ? (ex_rD1 + ex_sext) & ~XLEN'(1) :
                       act_taken ? ex_sext : ex_pc + XLEN'(4);
      // on a non-control instruction any predicted-taken is a stale alias
      redirect       = !rst && ex_valid &&
                       (ex_ctl ? act_taken != ex_pred_taken || (act_taken && actual != ex_pred_target) : ex_pred_taken);
      redirect_pc    = actual;
   end
   always_ff @(posedge clk)
      if (rst) pc_if <= RESET_PC;
      else if (redirect) pc_if <= redirect_pc;
      else if (!stall_if) pc_if <= pred_taken_if ? pred_target_if : pc4_if;
   npc_btb #(.XLEN(XLEN), .IDX_W(IDX_W)) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_if[IDX_W+1:2]),
      .rd_tag    (pc_if[XLEN-1:IDX_W+2]),
      .rd_hit    (rd_hit),
      .rd_taken  (rd_taken),
      .rd_target (rd_target),
      .we        (ex_valid && (ex_ctl || ex_pred_taken)),
      .wr_idx    (ex_pc[IDX_W+1:2]),
      .wr_sel    (ex_pc_sel),
      .wr_taken  (act_taken),
      .wr_tag    (ex_pc[XLEN-1:IDX_W+2]),
      .wr_target (ex_pc_sel == PC_SEL_BR ? ex_sext : actual)
   );
`ifdef NPC_BP_PERF_CNT_EN
   always_ff @(posedge clk)
      if (rst) begin
         perf_br_cnt  <= '0;
         perf_mis_cnt <= '0;
      end else begin
         perf_br_cnt  <= perf_br_cnt + 32'(ex_valid && ex_ctl);
         perf_mis_cnt <= perf_mis_cnt + 32'(redirect);
      end
`endif
endmodule
